// File: rtl/danger_scroller_pkg.sv
// Shared constants for the obstacle motion stage and sprite renderer.
// Also holds the scroller state encoding and the LFSR step function.
package danger_scroller_pkg;

    localparam int SCREEN_W       = 320;
    localparam int GROUND         = 150;
    localparam int DANGER1_WIDTH  = 26;
    localparam int DANGER1_HEIGHT = 40;

    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_GAP,
        ST_SCROLL,
        ST_FROZEN
    } state_e;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 16'h0000);
    endfunction

endpackage

// File: rtl/danger_scroller_lfsr16.sv
// Free-running 16-bit Galois LFSR, reloaded with SEED on reset.
// Kept standalone so obstacle-type selection can share it later.
module lfsr16
    import danger_scroller_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = lfsr_next(lfsr_q);
    assign q      = lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/danger_scroller.sv
// Obstacle motion stage: spawns off the right edge, scrolls left per
// game step, inserts random gaps and raises speed as obstacles pass.
module danger_scroller
    import danger_scroller_pkg::*;
#(
    parameter int          SPAWN_POS      = SCREEN_W + DANGER1_WIDTH,
    parameter int          MIN_GAP        = 40,
    parameter int          GAP_BITS       = 6,
    parameter int          SPEED_INIT     = 2,
    parameter int          SPEED_MAX      = 6,
    parameter int          SPEED_UP_EVERY = 4,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       step,
    input  logic       start,
    input  logic       halt,
    output logic [8:0] pos,
    output logic       on_screen,
    output logic       passed,
    output logic [2:0] speed
);

    localparam int PW = $clog2(SPEED_UP_EVERY + 1);

    state_e      state_q;
    logic [8:0]  pos_q;
    logic        passed_q;
    logic [2:0]  speed_q;
    logic [6:0]  gap_q;
    logic [PW-1:0] pass_q;

    logic [15:0] lfsr;
    logic        unused_lfsr;
    logic [8:0]  speed_ext;
    logic [8:0]  pos_d;
    logic [6:0]  gap_d;
    logic        exit_d;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:GAP_BITS];
    assign speed_ext   = {6'b000000, speed_q};
    assign exit_d      = (pos_q <= speed_ext);
    assign pos_d       = pos_q - speed_ext;
    assign gap_d       = 7'(MIN_GAP) + 7'(lfsr[GAP_BITS-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pos_q    <= '0;
            passed_q <= 1'b0;
            speed_q  <= 3'(SPEED_INIT);
            gap_q    <= '0;
            pass_q   <= '0;
        end else begin
            passed_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_WAIT_GAP;
                        gap_q   <= 7'(MIN_GAP);
                    end
                end
                ST_WAIT_GAP: begin
                    if (halt) begin
                        state_q <= ST_FROZEN;
                    end else if (step) begin
                        if (gap_q == '0) begin
                            pos_q   <= 9'(SPAWN_POS);
                            state_q <= ST_SCROLL;
                        end else begin
                            gap_q <= gap_q - 7'd1;
                        end
                    end
                end
                ST_SCROLL: begin
                    if (halt) begin
                        state_q <= ST_FROZEN;
                    end else if (step) begin
                        if (!exit_d) begin
                            pos_q <= pos_d;
                        end else begin
                            pos_q    <= '0;
                            passed_q <= 1'b1;
                            gap_q    <= gap_d;
                            state_q  <= ST_WAIT_GAP;
                            // Speed bumps on every SPEED_UP_EVERY-th exit
                            if (pass_q == PW'(SPEED_UP_EVERY - 1)) begin
                                pass_q <= '0;
                                if (speed_q < 3'(SPEED_MAX)) begin
                                    speed_q <= speed_q + 3'd1;
                                end
                            end else begin
                                pass_q <= pass_q + PW'(1);
                            end
                        end
                    end
                end
                ST_FROZEN: begin
                    if (start) begin
                        pos_q   <= '0;
                        speed_q <= 3'(SPEED_INIT);
                        pass_q  <= '0;
                        gap_q   <= 7'(MIN_GAP);
                        state_q <= ST_WAIT_GAP;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pos       = pos_q;
    assign passed    = passed_q;
    assign speed     = speed_q;
    assign on_screen = (state_q == ST_SCROLL);

endmodule

// File: tb/tb_danger_scroller.sv
// Randomised bench for danger_scroller against a behavioural model
// of the obstacle life cycle (idle, gap, scroll, frozen).
module tb_danger_scroller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       step = 1'b0;
    logic       start = 1'b0;
    logic       halt = 1'b0;
    logic [8:0] pos;
    logic       on_screen;
    logic       passed;
    logic [2:0] speed;

    int total = 0;
    int bad   = 0;

    danger_scroller dut (
        .clk       (clk),
        .rst       (rst),
        .step      (step),
        .start     (start),
        .halt      (halt),
        .pos       (pos),
        .on_screen (on_screen),
        .passed    (passed),
        .speed     (speed)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 waiting for gap, 2 on screen, 3 frozen
    int          m_mode, m_pos, m_speed, m_gap, m_npass, m_total_pass;
    bit          m_passed;
    logic [15:0] m_lfsr;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit st, input bit h);
        int old_rnd;
        if (r) begin
            m_mode = 0; m_pos = 0; m_passed = 0; m_speed = 2;
            m_gap = 0; m_npass = 0; m_lfsr = 16'hACE1;
            return;
        end
        old_rnd  = int'(m_lfsr % 64);
        m_lfsr   = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        m_passed = 0;
        case (m_mode)
            0: if (st) begin m_mode = 1; m_gap = 40; end
            1: begin
                if (h) m_mode = 3;
                else if (s) begin
                    if (m_gap == 0) begin m_pos = 346; m_mode = 2; end
                    else m_gap--;
                end
            end
            2: begin
                if (h) m_mode = 3;
                else if (s) begin
                    if (m_pos > m_speed) m_pos -= m_speed;
                    else begin
                        m_pos = 0; m_passed = 1; m_mode = 1;
                        m_gap = 40 + old_rnd;
                        m_total_pass++;
                        m_npass++;
                        if (m_npass == 4) begin
                            m_npass = 0;
                            if (m_speed < 6) m_speed++;
                        end
                    end
                end
            end
            default: if (st) begin
                m_pos = 0; m_speed = 2; m_npass = 0; m_gap = 40; m_mode = 1;
            end
        endcase
    endtask

    task automatic cyc(input bit s, input bit st, input bit h, input bit r);
        @(negedge clk);
        step = s; start = st; halt = h; rst = r;
        @(posedge clk);
        model_edge(r, s, st, h);
        #1;
        step = 0; start = 0; halt = 0; rst = 0;
        check("pos", int'(pos), m_pos);
        check("speed", int'(speed), m_speed);
        check("passed", int'(passed), int'(m_passed));
        check("on_screen", int'(on_screen), int'(m_mode == 2));
        if (pos >= 9'd500) check("pos_wrap", int'(pos), 0);
    endtask

    task automatic do_step();
        int idle = int'($urandom_range(0, 2));
        for (int i = 0; i < idle; i++) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
    endtask

    initial begin
        int budget;
        bit saw_pass;
        m_total_pass = 0;

        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        check("rst_pos", int'(pos), 0);
        check("rst_speed", int'(speed), 2);
        check("rst_on_screen", int'(on_screen), 0);

        // Steps without start leave the block idle
        saw_pass = 0;
        for (int i = 0; i < 10; i++) begin
            do_step();
            if (passed) saw_pass = 1;
        end
        check("idle_pos", int'(pos), 0);
        check("idle_passed", int'(saw_pass), 0);

        cyc(0, 1, 0, 0);
        for (int i = 0; i < 40; i++) do_step();
        check("gap40_pos", int'(pos), 0);
        do_step();
        check("spawn_pos", int'(pos), 346);
        check("spawn_on", int'(on_screen), 1);

        for (int i = 0; i < 172; i++) do_step();
        check("pre_exit_pos", int'(pos), 2);
        do_step();
        check("exit_pos", int'(pos), 0);
        check("exit_passed", int'(passed), 1);
        check("exit_on", int'(on_screen), 0);
        cyc(0, 0, 0, 0);
        check("passed_pulse", int'(passed), 0);

        // Run through twenty passes watching the speed ramp
        budget = 20000;
        while (m_total_pass < 20 && budget > 0) begin
            do_step();
            budget--;
            if (passed) begin
                if (m_total_pass == 4)  check("speed_p4", int'(speed), 3);
                if (m_total_pass == 16) check("speed_p16", int'(speed), 6);
                if (m_total_pass == 20) check("speed_p20", int'(speed), 6);
            end
        end
        if (budget == 0) check("budget_passes", 0, 1);

        // halt together with step at pos 100
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 41 + 123; i++) do_step();
        check("pre_halt_pos", int'(pos), 100);
        cyc(1, 0, 1, 0);
        check("halt_pos", int'(pos), 100);
        for (int i = 0; i < 5; i++) do_step();
        check("frozen_pos", int'(pos), 100);
        check("frozen_speed", int'(speed), 2);
        cyc(0, 1, 0, 0);
        check("restart_pos", int'(pos), 0);
        check("restart_speed", int'(speed), 2);
        for (int i = 0; i < 40; i++) do_step();
        check("restart_gap", int'(pos), 0);
        do_step();
        check("restart_spawn", int'(pos), 346);

        // Reach speed 4 mid-scroll, then reset
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        budget = 20000;
        while (!(m_speed == 4 && m_mode == 2 && m_pos <= 220) && budget > 0) begin
            do_step();
            budget--;
        end
        if (budget == 0) check("budget_speed4", 0, 1);
        check("mid_speed", int'(speed), 4);
        cyc(0, 0, 0, 1);
        check("rst2_pos", int'(pos), 0);
        check("rst2_speed", int'(speed), 2);
        check("rst2_passed", int'(passed), 0);
        check("rst2_on", int'(on_screen), 0);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 300; i++) do_step();

        // Free-running random traffic including halts and restarts
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0,
                $urandom_range(0, 300) == 0, $urandom_range(0, 2000) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
